// File: rtl/vvp_shacc_pkg.sv
// Shared types and sizing helpers for the vvp bit-serial shift-accumulator.
// The accumulator width function is shared with the vvp sizing logic.
package vvp_shacc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } vvp_shacc_state_t;

    localparam int PREC_W = 4;

    // Worst case |S| <= n sits in clog2(n)+2 signed bits; each plane index adds one bit of weight.
    function automatic int acc_width(input int n, input int wp, input int dp);
        return $clog2(n) + 2 + wp + dp;
    endfunction

    // A precision of 0 means a single plane; anything above the hardware limit is capped.
    function automatic logic [PREC_W-1:0] prec_clamp(input logic [PREC_W-1:0] p, input int pmax);
        if (p == '0)
            return PREC_W'(1);
        if (int'(p) > pmax)
            return PREC_W'(pmax);
        return p;
    endfunction

endpackage

// File: rtl/vvp_shacc_if.sv
// Control, beat-input and result handshakes of the shift-accumulator.
// The master side drives the product request and consumes the result.
interface vvp_shacc_if
    import vvp_shacc_pkg::*;
#(
    parameter int SW   = 8,
    parameter int ACCW = 24
) ();

    logic                   start;
    logic [PREC_W-1:0]      wprec;
    logic [PREC_W-1:0]      dprec;
    logic                   clear;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [SW-1:0]   in_s;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [ACCW-1:0] out_result;
    logic                   busy;

    modport master (
        output start, wprec, dprec, clear, in_valid, in_s, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  start, wprec, dprec, clear, in_valid, in_s, out_ready,
        output in_ready, out_valid, out_result, busy
    );

endinterface

// File: rtl/vvp_shacc_stage.sv
// One signed Horner stage: q_next = (first ? 0 : q <<< 1) + d, committed when en.
// The combinational next value is exported so a following stage can chain off it.
module shacc_stage #(
    parameter int W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                first,
    input  logic signed [W-1:0] d,
    output logic signed [W-1:0] q,
    output logic signed [W-1:0] nxt
);

    logic signed [W-1:0] base;

    assign base = first ? '0 : (q <<< 1);
    assign nxt  = base + d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= nxt;
    end

endmodule

// File: rtl/vvp_shacc.sv
// Bit-serial shift-accumulator: rebuilds a multi-bit dot product from per-plane
// partial sums (weight-bit outer, data-bit inner, MSB first) and hands it downstream.
module vvp_shacc
    import vvp_shacc_pkg::*;
#(
    parameter int N         = 64,
    parameter int WPREC_MAX = 8,
    parameter int DPREC_MAX = 8,
    parameter int SW        = $clog2(N) + 2,
    parameter int ACCW      = acc_width(N, WPREC_MAX, DPREC_MAX)
) (
    input logic        clk,
    input logic        rst_n,
    vvp_shacc_if.slave bus
);

    vvp_shacc_state_t       state, state_n;
    logic [PREC_W-1:0]      wprec_q, dprec_q;
    logic [PREC_W-1:0]      icnt, jcnt;
    logic signed [ACCW-1:0] result_q;

    logic                   beat, last_j, last_i;
    logic                   in_ready, out_valid, busy;
    logic signed [ACCW-1:0] s_ext;
    logic signed [ACCW-1:0] inner_q, inner_n;
    logic signed [ACCW-1:0] acc_q, acc_n;

    assign s_ext  = {{(ACCW-SW){bus.in_s[SW-1]}}, bus.in_s};
    assign beat   = bus.in_valid && in_ready && !bus.clear;
    assign last_j = (jcnt == dprec_q - PREC_W'(1));
    assign last_i = (icnt == wprec_q - PREC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_n = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (beat && last_j && last_i)
                    state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (bus.out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Abort outranks everything, including a start in IDLE.
        if (bus.clear)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wprec_q  <= '0;
            dprec_q  <= '0;
            icnt     <= '0;
            jcnt     <= '0;
            result_q <= '0;
        end else if (bus.clear) begin
            icnt     <= '0;
            jcnt     <= '0;
            result_q <= '0;
        end else if (state == IDLE && bus.start) begin
            wprec_q <= prec_clamp(bus.wprec, WPREC_MAX);
            dprec_q <= prec_clamp(bus.dprec, DPREC_MAX);
            icnt    <= '0;
            jcnt    <= '0;
        end else if (beat) begin
            if (last_j) begin
                jcnt <= '0;
                icnt <= icnt + PREC_W'(1);
                if (last_i)
                    result_q <= acc_n;
            end else begin
                jcnt <= jcnt + PREC_W'(1);
            end
        end
    end

    // Inner stage folds data planes; the outer stage folds each finished inner sum.
    shacc_stage #(.W(ACCW)) u_inner (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .en    (beat),
        .first (jcnt == '0),
        .d     (s_ext),
        .q     (inner_q),
        .nxt   (inner_n)
    );

    shacc_stage #(.W(ACCW)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .en    (beat && last_j),
        .first (icnt == '0),
        .d     (inner_n),
        .q     (acc_q),
        .nxt   (acc_n)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.busy       = busy;
    assign bus.out_result = result_q;

endmodule
